// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keccak_pkg
// Description : Shared constants for the Keccak-f core arbiter: default
//               permutation width, lane width, arbiter FSM encoding and a
//               round-robin pointer helper.
// Revision    : 1.0 - initial release
// ============================================================================
package keccak_pkg;

    localparam int unsigned c_keccak_b = 1600;
    localparam int unsigned c_lane_w   = 64;

    // Arbiter FSM encoding
    localparam int unsigned c_st_w     = 3;
    localparam logic [2:0]  c_st_idle  = 3'd0;
    localparam logic [2:0]  c_st_load  = 3'd1;
    localparam logic [2:0]  c_st_start = 3'd2;
    localparam logic [2:0]  c_st_wait  = 3'd3;
    localparam logic [2:0]  c_st_resp  = 3'd4;

    // Position after idx in a ring of n entries
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : keccak_rr_pick
// Description : Combinational round-robin picker. Scans i_req starting at
//               i_ptr and wrapping modulo N_REQ; the first set bit wins.
// Ports       : i_req    - request vector
//               i_ptr    - index with highest priority this cycle
//               o_onehot - one-hot winner (0 when no request)
//               o_idx    - binary winner index (0 when no request)
//               o_any    - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);

    int   w_k;
    logic w_found;

    assign o_any = |i_req;

    always_comb begin
        w_found  = 1'b0;
        w_k      = 0;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            // Candidate position (ptr + i) mod N_REQ
            w_k = int'(i_ptr) + i;
            if (w_k >= int'(N_REQ)) begin
                w_k = w_k - int'(N_REQ);
            end
            if (!w_found && i_req[w_k[IW-1:0]]) begin
                w_found                = 1'b1;
                o_idx                  = w_k[IW-1:0];
                o_onehot[w_k[IW-1:0]]  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keccak_f_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : keccak_f_share_arbiter
// Description : Shares one Keccak-f[B] permutation core between N_REQ sponge
//               controllers. Round-robin grant, loads the winner's state into
//               the core, pulses start, waits for done and returns the result
//               with a one-hot ack. A watchdog aborts a hung permutation.
// Ports       : i_clk, i_rst_n      - clock, async active-low reset
//               i_req / i_req_state - per-requester level request and state
//               o_grant / o_ack     - core owner (LOAD..RESP), 1-cycle ack
//               o_err / o_state     - timeout flag and permuted state
//               o_f_start/o_f_abort - core start and datapath-abort pulses
//               o_f_state           - registered state fed to the core
//               i_f_done/i_f_state  - core completion pulse and result
//               o_busy              - FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_f_share_arbiter
    import keccak_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned B       = c_keccak_b,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*B-1:0] i_req_state,
    output logic [N_REQ-1:0]   o_grant,
    output logic [N_REQ-1:0]   o_ack,
    output logic               o_err,
    output logic [B-1:0]       o_state,
    output logic               o_f_start,
    output logic               o_f_abort,
    output logic [B-1:0]       o_f_state,
    input  logic               i_f_done,
    input  logic [B-1:0]       i_f_state,
    output logic               o_busy
);

    localparam int unsigned     c_iw        = $clog2(N_REQ);
    localparam int unsigned     c_ww        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              c_wdog_en   = (TIMEOUT != 0);
    localparam logic [c_ww-1:0] c_wdog_last = (TIMEOUT > 0) ? c_ww'(TIMEOUT - 1) : '0;

    logic [c_st_w-1:0] r_fsm;
    logic [c_iw-1:0]   r_rr_ptr;
    logic [c_iw-1:0]   r_win;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  r_ack;
    logic              r_err;
    logic [B-1:0]      r_res;
    logic [B-1:0]      r_f_state;
    logic              r_f_start;
    logic [c_ww-1:0]   r_wdog;

    logic [N_REQ-1:0]  w_pick_onehot;
    logic [c_iw-1:0]   w_pick_idx;
    logic              w_pick_any;
    logic [B-1:0]      w_sel_state;
    logic              w_timeout;

    keccak_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (c_iw)
    ) u_pick (
        .i_req    (i_req),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // Winner's state slice; constant slice indices keep the mux shallow
    always_comb begin
        w_sel_state = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            if (r_win == c_iw'(k)) begin
                w_sel_state = i_req_state[k*B +: B];
            end
        end
    end

    assign w_timeout = c_wdog_en && (r_wdog == c_wdog_last);

    // A done in the last watchdog cycle takes priority, so abort only fires
    // when the core has not answered in that same cycle.
    assign o_f_abort = (r_fsm == c_st_wait) && !i_f_done && w_timeout;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fsm     <= c_st_idle;
            r_rr_ptr  <= '0;
            r_win     <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_res     <= '0;
            r_f_state <= '0;
            r_f_start <= 1'b0;
            r_wdog    <= '0;
        end else begin
            r_f_start <= 1'b0;
            r_ack     <= '0;
            case (r_fsm)
                c_st_idle: begin
                    if (w_pick_any) begin
                        r_win    <= w_pick_idx;
                        r_grant  <= w_pick_onehot;
                        r_rr_ptr <= c_iw'(rr_next(32'(w_pick_idx), N_REQ));
                        r_fsm    <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_f_state <= w_sel_state;
                    r_f_start <= 1'b1;
                    r_fsm     <= c_st_start;
                end
                c_st_start: begin
                    r_wdog <= '0;
                    r_fsm  <= c_st_wait;
                end
                c_st_wait: begin
                    r_wdog <= r_wdog + c_ww'(1);
                    if (i_f_done) begin
                        r_res <= i_f_state;
                        r_ack <= r_grant;
                        r_err <= 1'b0;
                        r_fsm <= c_st_resp;
                    end else if (w_timeout) begin
                        // o_state keeps the previous result on a timeout
                        r_ack <= r_grant;
                        r_err <= 1'b1;
                        r_fsm <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    r_err   <= 1'b0;
                    r_grant <= '0;
                    r_fsm   <= c_st_idle;
                end
                default: begin
                    r_grant <= '0;
                    r_err   <= 1'b0;
                    r_fsm   <= c_st_idle;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_ack     = r_ack;
    assign o_err     = r_err;
    assign o_state   = r_res;
    assign o_f_start = r_f_start;
    assign o_f_state = r_f_state;
    assign o_busy    = (r_fsm != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_keccak_f_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_keccak_f_share_arbiter
// Description : Self-checking bench for keccak_f_share_arbiter with a core
//               model (state XOR 0x5A.., programmable latency) and a queue
//               scoreboard fed by a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_f_share_arbiter;

    localparam int N    = 4;
    localparam int BW   = 1600;
    localparam int TO   = 64;
    localparam int KNOM = 24;

    typedef struct {
        int            idx;
        logic [BW-1:0] st;
        bit            err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*BW-1:0] req_state = '0;
    logic [N-1:0]    grant, ack;
    logic            err, fstart, fabort, busy;
    logic [BW-1:0]   ostate, fstate;
    logic            done_core = 1'b0;
    logic            done_spur = 1'b0;
    logic            f_done;
    logic [BW-1:0]   core_res = '0;
    logic [BW-1:0]   xmask = {200{8'h5A}};

    assign f_done = done_core | done_spur;

    keccak_f_share_arbiter #(
        .N_REQ   (N),
        .B       (BW),
        .TIMEOUT (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_req_state (req_state),
        .o_grant     (grant),
        .o_ack       (ack),
        .o_err       (err),
        .o_state     (ostate),
        .o_f_start   (fstart),
        .o_f_abort   (fabort),
        .o_f_state   (fstate),
        .i_f_done    (f_done),
        .i_f_state   (core_res),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bench state
    int            total = 0;
    int            bad = 0;
    exp_t          sbq[$];
    logic [BW-1:0] sreq[N];
    int            m_ptr = 0;
    logic [BW-1:0] m_ostate = '0;
    int            core_k = KNOM;
    bit            core_hang = 1'b0;
    int            hold_ops = 0;
    int            last_start_cyc = 0;
    int            last_ack_cyc = 0;
    int            abort_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        int lane;
        total++;
        if (act !== exp) begin
            bad++;
            lane = 0;
            for (int i = BW/64 - 1; i >= 0; i--)
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) lane = i;
            $display("FAIL %s lane %0d: got %h want %h", nm, lane, act[lane*64 +: 64], exp[lane*64 +: 64]);
        end
    endtask

    task automatic rand_states();
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < BW/32; w++) sreq[k][w*32 +: 32] = $urandom;
            req_state[k*BW +: BW] = sreq[k];
        end
    endtask

    // Reference: each served operation goes to the first pending requester
    // at or after the pointer (cyclically); the pointer then moves past it.
    task automatic plan(input logic [N-1:0] mask, input int nops, input bit hold, input bit tmo);
        logic [N-1:0] pend;
        int           w;
        exp_t         e;
        pend = mask;
        for (int n = 0; n < nops; n++) begin
            w = -1;
            for (int j = 0; j < N; j++)
                if (w < 0 && pend[(m_ptr + j) % N]) w = (m_ptr + j) % N;
            if (w < 0) break;
            if (!hold) pend[w] = 1'b0;
            m_ptr = (w + 1) % N;
            e.idx = w;
            e.err = tmo;
            e.st  = tmo ? m_ostate : (sreq[w] ^ xmask);
            m_ostate = e.st;
            sbq.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (sbq.size() != 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("drain_pending", sbq.size(), 0);
        if (sbq.size() != 0) begin
            sbq.delete();
            req = '0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic phase(input logic [N-1:0] mask, input int k, input bit hang);
        core_k    = k;
        core_hang = hang;
        plan(mask, $countones(mask), 1'b0, hang);
        req = mask;
        wait_drain(2000);
        core_hang = 1'b0;
    endtask

    // Enters reset at a negedge, checks the cleared outputs, then releases
    // with pend_mask still requesting.
    task automatic do_reset(input logic [N-1:0] pend_mask);
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", int'({grant, ack, err, fstart, fabort, busy}), 0);
        chk_st("rst_ostate", ostate, '0);
        chk_st("rst_fstate", fstate, '0);
        repeat (2) @(negedge clk);
        m_ptr    = 0;
        m_ostate = '0;
        core_k   = KNOM;
        if (pend_mask != '0) plan(pend_mask, $countones(pend_mask), 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                chk("grant_count", $countones(grant), busy ? 1 : 0);
                if (fstart) last_start_cyc = cyc;
                if (fabort) begin
                    abort_cnt++;
                    chk("abort_cycle", cyc - last_start_cyc, TO);
                end
                if (ack != '0) begin
                    last_ack_cyc = cyc;
                    if (sbq.size() == 0) begin
                        chk("unexpected_ack", int'(ack), 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("ack_owner", int'(ack), 1 << e.idx);
                        chk("grant_owner", int'(grant), 1 << e.idx);
                        chk("err_flag", int'(err), int'(e.err));
                        chk_st("result_state", ostate, e.st);
                    end
                end
            end
        end
    end

    // Requesters release i_req in the ack cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ack != '0) begin
                if (hold_ops > 0) begin
                    hold_ops--;
                    if (hold_ops == 0) req = '0;
                end else begin
                    req = req & ~ack;
                end
            end
        end
    end

    // Permutation core model
    initial begin
        logic [BW-1:0] cap;
        int            k;
        bit            killed;
        forever begin
            @(negedge clk);
            if (rst_n && fstart) begin
                cap    = fstate;
                k      = core_hang ? 300 : core_k;
                killed = 1'b0;
                for (int i = 0; i < k; i++) begin
                    @(negedge clk);
                    if (!rst_n || (fabort && i < k - 1)) begin
                        killed = 1'b1;
                        break;
                    end
                end
                if (!killed) begin
                    core_res  = cap ^ xmask;
                    done_core = 1'b1;
                    @(negedge clk);
                    done_core = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int t0;
        int a0;
        rand_states();
        repeat (2) @(negedge clk);
        do_reset('0);
        repeat (2) @(negedge clk);

        // Single request on requester 2: latency and result
        rand_states();
        t0 = cyc;
        phase(4'b0100, KNOM, 1'b0);
        chk("start_latency", last_start_cyc - t0, 2);
        chk("ack_latency", last_ack_cyc - t0, 3 + KNOM);

        // All four held continuously from reset: 0,1,2,3,0,1
        @(negedge clk);
        do_reset('0);
        @(negedge clk);
        rand_states();
        core_k   = KNOM;
        hold_ops = 6;
        plan(4'b1111, 6, 1'b1, 1'b0);
        req = 4'b1111;
        wait_drain(2000);

        // Pointer wrap: serve 3, then {1,3} -> 1 first
        rand_states();
        phase(4'b1000, 5, 1'b0);
        phase(4'b1010, 7, 1'b0);

        // Hung core: abort in the last watchdog cycle, ack with error
        a0 = abort_cnt;
        rand_states();
        phase(4'b0010, KNOM, 1'b1);
        chk("abort_count", abort_cnt - a0, 1);

        // Done pulses outside WAIT are ignored
        core_res  = {50{32'hDEADBEEF}};
        done_spur = 1'b1;
        @(negedge clk);
        done_spur = 1'b0;
        @(negedge clk);
        #1;
        chk_st("idle_done_state", ostate, m_ostate);
        chk("idle_done_busy", int'(busy), 0);
        @(negedge clk);
        rand_states();
        core_k = KNOM;
        plan(4'b0001, 1, 1'b0, 1'b0);
        req = 4'b0001;
        @(negedge clk);
        done_spur = 1'b1;
        @(negedge clk);
        done_spur = 1'b0;
        wait_drain(2000);

        // Done in the same cycle as the timeout: done wins
        a0 = abort_cnt;
        rand_states();
        phase(4'b0100, TO, 1'b0);
        chk("collide_abort", abort_cnt - a0, 0);

        // Request dropped early still completes
        rand_states();
        core_k = 10;
        plan(4'b0010, 1, 1'b0, 1'b0);
        req = 4'b0010;
        repeat (4) @(negedge clk);
        req = '0;
        wait_drain(2000);

        // Randomized phases
        for (int p = 0; p < 20; p++) begin
            rand_states();
            phase(4'($urandom_range(1, 15)), $urandom_range(1, 40), 1'b0);
        end

        // Reset during WAIT, pending requests restart from pointer 0
        rand_states();
        core_k = KNOM;
        req    = 4'b1001;
        repeat (12) @(negedge clk);
        do_reset(4'b1001);
        wait_drain(2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
